// File: rtl/exe_unit_sequencer.sv
// exe_unit_sequencer: operand bypass, single-op dispatch, result FIFO to write-back (optional stall counter via EXE_STALL_CNT_EN)
module exe_unit_sequencer #(
  parameter int XLEN     = 64,
  parameter int NUM_BYP  = 2,
  parameter int WB_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    kill_i,
  input  logic                    instr_valid_i,
  input  logic [2:0]              unit_i,
  input  logic [4:0]              rs1_i,
  input  logic [4:0]              rs2_i,
  input  logic [4:0]              rd_i,
  input  logic [XLEN-1:0]         rs1_data_i,
  input  logic [XLEN-1:0]         rs2_data_i,
  input  logic                    use_imm_i,
  input  logic [XLEN-1:0]         imm_i,
  input  logic [NUM_BYP-1:0]      byp_valid_i,
  input  logic [5*NUM_BYP-1:0]    byp_rd_i,
  input  logic [XLEN*NUM_BYP-1:0] byp_data_i,
  output logic [XLEN-1:0]         op_rs1_o,
  output logic [XLEN-1:0]         op_rs2_o,
  output logic [XLEN-1:0]         op_rs2_reg_o,
  output logic [4:0]              unit_req_o,
  input  logic [4:0]              unit_done_i,
  input  logic [5*XLEN-1:0]       unit_result_i,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [4:0]              wb_rd_o,
  output logic [XLEN-1:0]         wb_data_o,
  output logic                    stall_o,
  output logic [31:0]             stall_cnt_o
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam logic [2:0] U_ALU = 3'd0, U_MUL = 3'd1, U_DIV = 3'd2, U_BR = 3'd3, U_MEM = 3'd4;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t          state_q, state_d;
  logic [2:0]      unit_q;
  logic [4:0]      rd_q;
  logic [PW:0]     count_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]      fifo_rd [WB_DEPTH];
  logic [XLEN-1:0] fifo_data [WB_DEPTH];
  logic [XLEN-1:0] res [8];
  logic [7:0]      done8;
  logic            accept, is_multi, push, pop;
  logic [4:0]      push_rd;
  logic [XLEN-1:0] push_data;
  logic [XLEN-1:0] rs2_byp;
  for (genvar i = 0; i < 8; i++) begin : g_res
    if (i < 5) begin : g_u
      assign res[i] = unit_result_i[i*XLEN +: XLEN];
    end else begin : g_z
      assign res[i] = '0;
    end
  end
  assign done8        = {3'b000, unit_done_i};
  assign stall_o      = (state_q == S_WAIT) | (count_q == (PW+1)'(WB_DEPTH));
  assign accept       = instr_valid_i & ~stall_o & ~kill_i;
  assign is_multi     = (unit_i == U_MUL) | (unit_i == U_DIV) | (unit_i == U_MEM);
  assign wb_valid_o   = count_q != '0;
  assign pop          = wb_valid_o & wb_ready_i & ~kill_i;
  assign wb_rd_o      = fifo_rd[rd_ptr_q];
  assign wb_data_o    = fifo_data[rd_ptr_q];
  assign op_rs2_o     = use_imm_i ? imm_i : rs2_byp;
  assign op_rs2_reg_o = rs2_byp;
  // bypass select: walk from oldest to youngest so the lowest matching index wins
  always_comb begin
    op_rs1_o = rs1_data_i;
    rs2_byp  = rs2_data_i;
    for (int k = NUM_BYP - 1; k >= 0; k--) begin
      if (byp_valid_i[k] && byp_rd_i[k*5 +: 5] == rs1_i && rs1_i != 5'd0) op_rs1_o = byp_data_i[k*XLEN +: XLEN];
      if (byp_valid_i[k] && byp_rd_i[k*5 +: 5] == rs2_i && rs2_i != 5'd0) rs2_byp = byp_data_i[k*XLEN +: XLEN];
    end
  end
  // next state, unit request and FIFO push; kill suppresses done and forces IDLE
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_rd    = rd_i;
    push_data  = '0;
    unit_req_o = '0;
    if (accept) begin
      if (is_multi) begin
        unit_req_o = 5'b00001 << unit_i;
        state_d    = S_WAIT;
      end else begin
        push      = 1'b1;
        push_data = (unit_i == U_ALU || unit_i == U_BR) ? res[unit_i] : '0;
      end
    end else if (state_q == S_WAIT && done8[unit_q] && !kill_i) begin
      push      = 1'b1;
      push_rd   = rd_q;
      push_data = res[unit_q];
      state_d   = S_IDLE;
    end
    if (kill_i) state_d = S_IDLE;
  end
  // state register and latched unit/rd of the outstanding operation
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      unit_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept && is_multi) begin
        unit_q <= unit_i;
        rd_q   <= rd_i;
      end
    end
  end
  // result FIFO; storage is cleared on reset so the head reads 0 until first push
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int j = 0; j < WB_DEPTH; j++) begin
        fifo_rd[j]   <= '0;
        fifo_data[j] <= '0;
      end
    end else if (kill_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        fifo_rd[wr_ptr_q]   <= push_rd;
        fifo_data[wr_ptr_q] <= push_data;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
`ifdef EXE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  // saturating count of cycles a valid instruction is held off
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) stall_cnt_q <= '0;
    else if (instr_valid_i && stall_o && !kill_i && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_exe_unit_sequencer.sv
// tb_exe_unit_sequencer: directed checks of bypass, dispatch, FIFO, kill and reset
module tb_exe_unit_sequencer;
  localparam int XLEN = 64;
  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            kill_i, instr_valid_i, use_imm_i, wb_ready_i;
  logic [2:0]      unit_i;
  logic [4:0]      rs1_i, rs2_i, rd_i;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i, imm_i;
  logic [1:0]      byp_valid_i;
  logic [9:0]      byp_rd_i;
  logic [2*XLEN-1:0] byp_data_i;
  logic [XLEN-1:0] op_rs1_o, op_rs2_o, op_rs2_reg_o;
  logic [4:0]      unit_req_o, unit_done_i;
  logic [5*XLEN-1:0] unit_result_i;
  logic            wb_valid_o, stall_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic [31:0]     stall_cnt_o;
  int checks = 0;
  int errors = 0;
  exe_unit_sequencer #(.XLEN(XLEN), .NUM_BYP(2), .WB_DEPTH(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .kill_i(kill_i), .instr_valid_i(instr_valid_i),
    .unit_i(unit_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .use_imm_i(use_imm_i), .imm_i(imm_i),
    .byp_valid_i(byp_valid_i), .byp_rd_i(byp_rd_i), .byp_data_i(byp_data_i),
    .op_rs1_o(op_rs1_o), .op_rs2_o(op_rs2_o), .op_rs2_reg_o(op_rs2_reg_o),
    .unit_req_o(unit_req_o), .unit_done_i(unit_done_i), .unit_result_i(unit_result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_res(input int k, input logic [63:0] v);
    unit_result_i[k*XLEN +: XLEN] = v;
  endtask
  initial begin
    rstn_i = 1'b0; kill_i = 0; instr_valid_i = 0; use_imm_i = 0; wb_ready_i = 1;
    unit_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0; rs1_data_i = 0; rs2_data_i = 0; imm_i = 0;
    byp_valid_i = 0; byp_rd_i = 0; byp_data_i = 0; unit_done_i = 0; unit_result_i = 0;
    #2;
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_unit_req", unit_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    chk("rst_wb_rd", wb_rd_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    rstn_i = 1'b1;
    tick();
    rs1_i = 5; rs2_i = 5; byp_valid_i = 2'b11; byp_rd_i = {5'd5, 5'd5};
    byp_data_i = {64'hB, 64'hA}; use_imm_i = 1; imm_i = 64'h99;
    #1;
    chk("byp_prio_rs1", op_rs1_o, 64'hA);
    chk("byp_imm_rs2", op_rs2_o, 64'h99);
    chk("byp_rs2_reg", op_rs2_reg_o, 64'hA);
    byp_valid_i = 2'b10;
    #1;
    chk("byp_older_rs1", op_rs1_o, 64'hB);
    rs1_i = 0; rs1_data_i = 64'h77; byp_valid_i = 2'b11; byp_rd_i = 0;
    #1;
    chk("byp_x0_rs1", op_rs1_o, 64'h77);
    byp_valid_i = 0; use_imm_i = 0; rs2_data_i = 64'h66;
    #1;
    chk("byp_none_rs2", op_rs2_o, 64'h66);
    rs2_i = 0;
    for (int i = 0; i < 4; i++) begin
      instr_valid_i = 1; unit_i = 0; rd_i = 5'(1 + i); set_res(0, 64'h100 + 64'(i));
      #1;
      chk("alu_stall", stall_o, 0);
      chk("alu_req", unit_req_o, 0);
      if (i > 0) begin
        chk("alu_wb_valid", wb_valid_o, 1);
        chk("alu_wb_rd", wb_rd_o, 64'(i));
        chk("alu_wb_data", wb_data_o, 64'h100 + 64'(i - 1));
      end
      tick();
    end
    instr_valid_i = 0;
    #1;
    chk("alu_last_rd", wb_rd_o, 4);
    chk("alu_last_data", wb_data_o, 64'h103);
    tick();
    chk("alu_drained", wb_valid_o, 0);
    instr_valid_i = 1; unit_i = 3; rd_i = 5; set_res(3, 64'h333);
    tick();
    unit_i = 6; rd_i = 6;
    #1;
    chk("br_wb_rd", wb_rd_o, 5);
    chk("br_wb_data", wb_data_o, 64'h333);
    tick();
    instr_valid_i = 0;
    #1;
    chk("inv_wb_rd", wb_rd_o, 6);
    chk("inv_wb_data", wb_data_o, 0);
    tick();
    instr_valid_i = 1; unit_i = 2; rd_i = 7; set_res(2, 64'hDEAD); unit_done_i = 5'b00100;
    #1;
    chk("div_req", unit_req_o, 5'b00100);
    chk("div_accept_stall", stall_o, 0);
    tick();
    unit_i = 0; rd_i = 9; set_res(0, 64'h55);
    for (int c = 1; c <= 10; c++) begin
      unit_done_i = (c == 5) ? 5'b00010 : (c == 10) ? 5'b00100 : 5'b00000;
      if (c == 10) set_res(2, 64'h1234);
      #1;
      chk("div_wait_stall", stall_o, 1);
      chk("div_wait_wb_valid", wb_valid_o, 0);
      chk("div_wait_req", unit_req_o, 0);
      tick();
    end
    unit_done_i = 0;
    #1;
    chk("div_wb_valid", wb_valid_o, 1);
    chk("div_wb_rd", wb_rd_o, 7);
    chk("div_wb_data", wb_data_o, 64'h1234);
    chk("div_next_stall", stall_o, 0);
    tick();
    instr_valid_i = 0;
    #1;
    chk("div_next_rd", wb_rd_o, 9);
    chk("div_next_data", wb_data_o, 64'h55);
`ifdef EXE_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, 10);
`else
    chk("stall_cnt", stall_cnt_o, 0);
`endif
    tick();
    chk("div_drained", wb_valid_o, 0);
    wb_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      instr_valid_i = 1; unit_i = 0; rd_i = 5'(10 + i); set_res(0, 64'h200 + 64'(i));
      #1;
      chk("full_fill_stall", stall_o, 0);
      tick();
    end
    rd_i = 14; set_res(0, 64'h204);
    #1;
    chk("full_stall", stall_o, 1);
    chk("full_head", wb_rd_o, 10);
    tick();
    chk("full_stall_hold", stall_o, 1);
    wb_ready_i = 1;
    #1;
    chk("full_pop_data", wb_data_o, 64'h200);
    tick();
    chk("full_release", stall_o, 0);
    chk("full_head2", wb_rd_o, 11);
    tick();
    instr_valid_i = 0;
    for (int j = 12; j <= 14; j++) begin
      #1;
      chk("full_order_rd", wb_rd_o, 64'(j));
      chk("full_order_data", wb_data_o, 64'h200 + 64'(j - 10));
      tick();
    end
    chk("full_drained", wb_valid_o, 0);
    wb_ready_i = 0;
    instr_valid_i = 1; unit_i = 0; rd_i = 20; set_res(0, 64'h20);
    tick();
    rd_i = 21;
    tick();
    unit_i = 1; rd_i = 22;
    #1;
    chk("kill_mul_req", unit_req_o, 5'b00010);
    tick();
    instr_valid_i = 0;
    #1;
    chk("kill_wait_stall", stall_o, 1);
    chk("kill_head", wb_rd_o, 20);
    tick();
    kill_i = 1; unit_done_i = 5'b00010; set_res(1, 64'h999);
    tick();
    kill_i = 0; unit_done_i = 0;
    #1;
    chk("kill_wb_valid", wb_valid_o, 0);
    chk("kill_stall", stall_o, 0);
    instr_valid_i = 1; unit_i = 0; rd_i = 23; set_res(0, 64'h23);
    #1;
    chk("kill_idle_req", unit_req_o, 0);
    tick();
    instr_valid_i = 0;
    chk("kill_after_valid", wb_valid_o, 1);
    chk("kill_after_rd", wb_rd_o, 23);
    chk("kill_after_data", wb_data_o, 64'h23);
    wb_ready_i = 1; instr_valid_i = 1; unit_i = 1; kill_i = 1;
    #1;
    chk("kill_blocks_req", unit_req_o, 0);
    tick();
    kill_i = 0; instr_valid_i = 0;
    #1;
    chk("kill_blocks_stall", stall_o, 0);
    chk("kill_flush_valid", wb_valid_o, 0);
    instr_valid_i = 1; unit_i = 2; rd_i = 30;
    tick();
    instr_valid_i = 0;
    #1;
    chk("arst_pre_stall", stall_o, 1);
    rstn_i = 0;
    #1;
    chk("arst_stall", stall_o, 0);
    chk("arst_wb_valid", wb_valid_o, 0);
    rstn_i = 1;
    tick();
    chk("arst_after_valid", wb_valid_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
